// File: rtl/angle_to_radian_pipe.sv
// Degree-to-radian converter feeding the CORDIC sin/cos core.
// Three pipeline stages: modulo-360 reduction, optional quadrant fold,
// and fixed-point scaling by pi/180 with round-half-up on the magnitude.
// One global advance enable stalls every stage when the output is blocked.
module angle_to_radian_pipe #(
  parameter int ANGLE_W = 9,
  parameter int FRAC_W  = 16,
  parameter int OUT_W   = 32,
  parameter int FOLD    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ANGLE_W-1:0]       angle,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  radian,
  output logic                     cos_neg
);

  // Product width: 9-bit magnitude times a scale constant of about FRAC_W+11 bits
  localparam int  PW   = ANGLE_W + FRAC_W + 12;
  // Largest multiple of 360 that can appear in an ANGLE_W-bit input
  localparam int  NMUL = ((1 << ANGLE_W) - 1) / 360;
  localparam real PI   = 3.14159265358979323846;

  // Scale constant round(pi/180 * 2^(FRAC_W+16)), evaluated at elaboration.
  // Floor is taken explicitly so the result does not depend on how the
  // real-to-integer cast rounds.
  function automatic longint calc_k();
    real    kr;
    longint kf;
    kr = PI / 180.0 * (2.0 ** (FRAC_W + 16));
    kf = longint'(kr);
    if (real'(kf) > kr) kf = kf - 1;
    if ((kr - real'(kf)) >= 0.5) kf = kf + 1;
    return kf;
  endfunction

  localparam logic [PW-1:0] K = PW'(calc_k());

  // Round-half-up of the 16 extra guard bits, returning the magnitude
  function automatic logic [OUT_W-1:0] round_shift(input logic [PW-1:0] p);
    logic [PW-1:0] s;
    s = p + PW'(32768);
    return OUT_W'(s >> 16);
  endfunction

  // Sign is applied after rounding so negatives mirror positives exactly
  function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                         input logic            neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  logic                     w_en;
  logic [ANGLE_W-1:0]       w_sel;
  logic [8:0]               w_mod;
  logic [8:0]               r_mod_p0;
  logic                     r_vld_p0;
  logic [8:0]               w_mag;
  logic                     w_neg;
  logic                     w_cneg;
  logic [8:0]               r_mag_p1;
  logic                     r_neg_p1;
  logic                     r_cneg_p1;
  logic                     r_vld_p1;
  logic [PW-1:0]            w_prod;
  logic signed [OUT_W-1:0]  w_rad;
  logic signed [OUT_W-1:0]  r_rad_p2;
  logic                     r_cneg_p2;
  logic                     r_vld_p2;

  assign w_en      = !r_vld_p2 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld_p2;
  assign radian    = r_rad_p2;
  assign cos_neg   = r_cneg_p2;

  // ---- stage 1: modulo 360 by picking the largest multiple not above the input
  always_comb begin
    w_sel = '0;
    for (int j = 1; j <= NMUL; j++) begin
      if (32'(angle) >= 32'(360 * j)) w_sel = ANGLE_W'(360 * j);
    end
    w_mod = 9'(angle - w_sel);
  end

  // ---- stage 2: fold into [-90, +90] degrees and flag cos negation
  always_comb begin
    w_mag  = r_mod_p0;
    w_neg  = 1'b0;
    w_cneg = 1'b0;
    if (FOLD != 0) begin
      if (r_mod_p0 <= 9'd90) begin
        w_mag = r_mod_p0;
      end else if (r_mod_p0 <= 9'd269) begin
        w_cneg = 1'b1;
        if (r_mod_p0 > 9'd180) begin
          w_mag = r_mod_p0 - 9'd180;
          w_neg = 1'b1;
        end else begin
          w_mag = 9'd180 - r_mod_p0;
        end
      end else begin
        w_mag = 9'd360 - r_mod_p0;
        w_neg = 1'b1;
      end
    end
  end

  // ---- stage 3: scale to fixed-point radians
  always_comb begin
    w_prod = PW'(r_mag_p1) * K;
    w_rad  = apply_sign(round_shift(w_prod), r_neg_p1);
  end

  // Valid pipeline and visible outputs; cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_rad_p2  <= '0;
      r_cneg_p2 <= 1'b0;
    end else if (w_en) begin
      r_vld_p0  <= in_valid;
      r_vld_p1  <= r_vld_p0;
      r_vld_p2  <= r_vld_p1;
      r_rad_p2  <= w_rad;
      r_cneg_p2 <= r_cneg_p1;
    end
  end

  // Internal datapath registers advance with the enable; no reset needed
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_mod_p0  <= w_mod;
      r_mag_p1  <= w_mag;
      r_neg_p1  <= w_neg;
      r_cneg_p1 <= w_cneg;
    end
  end

endmodule

// File: tb/tb_angle_to_radian_pipe.sv
// Directed bench for angle_to_radian_pipe: three instances cover the
// default unfolded build, the folded build and a wide-angle/wide-fraction build.
module tb_angle_to_radian_pipe;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance 0: FOLD=0, defaults
  logic              iv0 = 1'b0, or0 = 1'b0;
  logic              ir0, ov0, cn0;
  logic [8:0]        ang0 = '0;
  logic signed [31:0] rad0;
  // Instance 1: FOLD=1
  logic              iv1 = 1'b0, or1 = 1'b0;
  logic              ir1, ov1, cn1;
  logic [8:0]        ang1 = '0;
  logic signed [31:0] rad1;
  // Instance 2: ANGLE_W=12, FRAC_W=20, OUT_W=28
  logic              iv2 = 1'b0, or2 = 1'b0;
  logic              ir2, ov2, cn2;
  logic [11:0]       ang2 = '0;
  logic signed [27:0] rad2;

  angle_to_radian_pipe #(.ANGLE_W(9), .FRAC_W(16), .OUT_W(32), .FOLD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .angle(ang0),
    .out_valid(ov0), .out_ready(or0), .radian(rad0), .cos_neg(cn0));

  angle_to_radian_pipe #(.ANGLE_W(9), .FRAC_W(16), .OUT_W(32), .FOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .angle(ang1),
    .out_valid(ov1), .out_ready(or1), .radian(rad1), .cos_neg(cn1));

  angle_to_radian_pipe #(.ANGLE_W(12), .FRAC_W(20), .OUT_W(28), .FOLD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .angle(ang2),
    .out_valid(ov2), .out_ready(or2), .radian(rad2), .cos_neg(cn2));

  function automatic real ref_rad(input int deg, input int frac);
    return real'(deg % 360) * PI / 180.0 * (2.0 ** frac);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [63:0] obs, input real exp);
    real d;
    checks++;
    d = real'(obs) - exp;
    assert (!$isunknown(obs) && (d <= 1.0) && (d >= -1.0)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%f (+/-1)", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nout, nin, first, cyc, extra;
    logic prev_stall;
    logic signed [31:0] prev_rad;
    int  f_ang[6];
    int  f_rad[6];
    logic f_cn[6];
    int  w_ang[3];

    f_ang = '{45, 135, 180, 225, 270, 359};
    f_rad = '{51472, 51472, 0, -51472, -102944, -1144};
    f_cn  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    w_ang = '{4095, 720, 4000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov0, 0);
    chk("rst_radian", rad0, 0);
    chk("rst_in_ready", ir0, 1);
    chk("rst_cos_neg_fold", cn1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream with the output blocked
    or0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv0 = 1'b1; ang0 = 9'(10 * (i + 1));
      @(posedge clk); #1;
    end
    iv0 = 1'b0;
    @(negedge clk);
    chk("stall_first_valid", ov0, 1);
    chk("stall_first_radian", rad0, 11438);
    chk("stall_in_ready_low", ir0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov0, 0);
    chk("async_rst_radian", rad0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    or0 = 1'b1;
    iv0 = 1'b1; ang0 = 9'd45;
    @(posedge clk); #1;
    iv0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("post_rst_latency", ov0, (k == 3) ? 1 : 0);
    end
    chk("post_rst_radian", rad0, 51472);
    @(posedge clk); #1;

    // FOLD=0 sweep 0..511 back to back
    nout = 0; first = -1;
    for (int c = 0; c < 515; c++) begin
      if (c < 512) begin iv0 = 1'b1; ang0 = 9'(c); end
      else iv0 = 1'b0;
      @(negedge clk);
      if (ov0 === 1'b1) begin
        if (first < 0) first = c;
        chk_near("sweep", rad0, ref_rad(nout, 16));
        if (nout == 90)  chk("sweep_90", rad0, 102944);
        if (nout == 180) chk("sweep_180", rad0, 205887);
        if (nout == 360) chk("sweep_360", rad0, 0);
        if (nout == 450) chk("sweep_450", rad0, 102944);
        if ((nout % 128) == 0) chk("sweep_cos_neg", cn0, 0);
        nout++;
      end
      @(posedge clk); #1;
    end
    chk("sweep_latency", first, 3);
    chk("sweep_count", nout, 512);

    // FOLD=1 corners
    or1 = 1'b1; nout = 0;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin iv1 = 1'b1; ang1 = 9'(f_ang[c]); end
      else iv1 = 1'b0;
      @(negedge clk);
      if (ov1 === 1'b1 && nout < 6) begin
        chk("fold_radian", rad1, f_rad[nout]);
        chk("fold_cos_neg", cn1, f_cn[nout]);
        nout++;
      end
      @(posedge clk); #1;
    end
    chk("fold_count", nout, 6);
    chk("fold_in_ready", ir1, 1);

    // Backpressure stream 0..20
    nout = 0; nin = 0; cyc = 0; prev_stall = 1'b0; prev_rad = '0;
    while (nout < 21 && cyc < 400) begin
      or0 = 1'($urandom_range(0, 1));
      iv0 = (nin < 21);
      ang0 = 9'(nin);
      @(negedge clk);
      chk("bp_in_ready", ir0, (ov0 && !or0) ? 0 : 1);
      if (prev_stall) begin
        chk("bp_hold_valid", ov0, 1);
        chk("bp_hold_radian", rad0, prev_rad);
      end
      if (ov0 && or0) begin
        chk_near("bp_data", rad0, ref_rad(nout, 16));
        nout++;
      end
      if (iv0 && ir0) nin++;
      prev_stall = ov0 && !or0;
      prev_rad = rad0;
      cyc++;
      @(posedge clk); #1;
    end
    chk("bp_count", nout, 21);
    iv0 = 1'b0; or0 = 1'b1; extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov0 === 1'b1) extra++;
      @(posedge clk); #1;
    end
    chk("bp_no_duplicate", extra, 0);

    // Wide build: ANGLE_W=12, FRAC_W=20
    or2 = 1'b1; nout = 0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin iv2 = 1'b1; ang2 = 12'(w_ang[c]); end
      else iv2 = 1'b0;
      @(negedge clk);
      if (ov2 === 1'b1 && nout < 3) begin
        chk_near("wide_radian", rad2, ref_rad(w_ang[nout], 20));
        if (nout == 1) chk("wide_720", rad2, 0);
        chk("wide_cos_neg", cn2, 0);
        nout++;
      end
      @(posedge clk); #1;
    end
    chk("wide_count", nout, 3);
    chk("wide_in_ready", ir2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/angle_to_radian_pipe.md
Name: angle_to_radian_pipe

Overview:
- Pipelined, parametrised degree-to-radian converter that feeds the CORDIC sin/cos core.
- Accepts unsigned integer degrees of any value up to 2^ANGLE_W-1 and reduces them modulo 360.
- Optionally folds the angle into the CORDIC convergence range [-90°, +90°] and flags when cos must be negated.
- Emits a signed fixed-point radian value. Uses a valid/ready handshake with backpressure and a fixed 3-stage latency.

Parameters:
- ANGLE_W, 9, input angle width in integer degrees; legal range 9..12.
- FRAC_W, 16, fractional bits of the output radian.
- OUT_W, 32, output width, two's complement, Q(OUT_W-FRAC_W).FRAC_W.
- FOLD, 0, 0 = output range [0, 2π); 1 = fold to [-π/2, +π/2] and drive cos_neg.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input angle valid.
- in_ready  out  1  block can accept an input this cycle.
- angle  in  ANGLE_W  unsigned integer degrees.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- radian  out  OUT_W  signed radian, FRAC_W fractional bits.
- cos_neg  out  1  FOLD=1 only: the consumer must negate cos; tied 0 when FOLD=0.

Behaviour:
- Reset (rst_n low, async): all stage valids, out_valid, radian and cos_neg go to 0 immediately; in-flight data is discarded. Release is synchronous to clk.
- Advance enable: en = !out_valid || out_ready; in_ready = en. When en=1 every stage register loads from its predecessor, including bubbles. When en=0 all stages hold.
- Handshake: an input transfers when in_valid && in_ready. An output transfers when out_valid && out_ready. Holding angle stable is not required after the transfer. Bubbles are not collapsed.
- Latency is exactly 3 en-cycles from input transfer to out_valid. Throughput is 1/cycle while out_ready=1.
- Stage 1, modulo: a = angle mod 360, range 0..359. Implement as a compare/subtract chain over multiples of 360 up to 360*floor((2^ANGLE_W-1)/360). No divider.
- Stage 2, fold, FOLD=1:
  - a ≤ 90: m = a, neg = 0, cos_neg = 0.
  - 91 ≤ a ≤ 269: d = 180 - a; m = |d|, neg = (d < 0), cos_neg = 1.
  - a ≥ 270: m = 360 - a, neg = 1, cos_neg = 0.
- Stage 2, FOLD=0: m = a, neg = 0, cos_neg = 0.
- Stage 3, scale:
  - K = round(π/180 · 2^(FRAC_W+16)); K = 74961321 for FRAC_W=16.
  - p = m·K, full width ANGLE_W+FRAC_W+12 bits.
  - r = (p + 2^15) >> 16, round-half-up on the magnitude.
  - radian = neg ? -r : r, sign-extended to OUT_W. Negatives are symmetric with positives.
- Accuracy: |radian - exact·2^FRAC_W| ≤ 1 LSB for every input.
- Overflow: not possible for legal parameters; the maximum magnitude is 2π·2^FRAC_W.
- radian and cos_neg hold their value while out_valid && !out_ready.
- Simultaneous input and output transfer in the same cycle is legal and loses no data.

Test Plan:
- Reset mid-stream: feed 3 angles, assert rst_n low with out_ready=0 -> out_valid=0, radian=0 immediately; after release the first new input emerges exactly 3 cycles later.
- FOLD=0 sweep 0..511 back-to-back with out_ready=1 -> one output per cycle, in order:
  - 90 -> 102944
  - 180 -> 205887
  - 360 -> 0
  - 450 -> 102944
  - every value within 1 LSB of round((i mod 360)·π/180·65536).
- FOLD=1 corners:
  - 45 -> 51472, cos_neg 0
  - 135 -> 51472, cos_neg 1
  - 180 -> 0, cos_neg 1
  - 225 -> -51472, cos_neg 1
  - 270 -> -102944, cos_neg 0
  - 359 -> -1144, cos_neg 0
- Backpressure: stream 0..20 with out_ready toggled pseudo-randomly -> no loss or duplication; radian stable while stalled; in_ready low exactly when out_valid && !out_ready.
- Parameter sweep ANGLE_W=12, FRAC_W=20, OUT_W=28: input 4095 -> 4095 mod 360 = 135° -> round(135·π/180·2^20), within 1 LSB.
